// File: rtl/tlc_pkg.sv
// Shared types for the junction phase controller: state encoding, lamp codes and lamp decode.
package tlc_pkg;

  typedef enum logic [3:0] {
    MAIN_GRN = 4'd0,
    M2_YEL   = 4'd1,
    MT_GRN   = 4'd2,
    M1MT_YEL = 4'd3,
    ALLRED1  = 4'd4,
    SIDE_GRN = 4'd5,
    SIDE_YEL = 4'd6,
    ALLRED2  = 4'd7,
    FLASH    = 4'd8
  } state_t;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;
  localparam logic [2:0] LT_OFF = 3'b000;

  typedef struct packed {
    logic [2:0] m1;
    logic [2:0] m2;
    logic [2:0] mt;
    logic [2:0] s;
  } lights_t;

  // Anything not explicitly lit stays red, so an unknown encoding never blanks the junction.
  function automatic lights_t decode_lights(state_t st, logic blink);
    lights_t l;
    l = '{m1: LT_RED, m2: LT_RED, mt: LT_RED, s: LT_RED};
    case (st)
      MAIN_GRN: begin l.m1 = LT_GRN; l.m2 = LT_GRN; end
      M2_YEL:   begin l.m1 = LT_GRN; l.m2 = LT_YEL; end
      MT_GRN:   begin l.m1 = LT_GRN; l.mt = LT_GRN; end
      M1MT_YEL: begin l.m1 = LT_YEL; l.mt = LT_YEL; end
      SIDE_GRN: l.s = LT_GRN;
      SIDE_YEL: l.s = LT_YEL;
      FLASH: begin
        l.m1 = blink ? LT_YEL : LT_OFF;
        l.m2 = blink ? LT_YEL : LT_OFF;
        l.mt = blink ? LT_RED : LT_OFF;
        l.s  = blink ? LT_RED : LT_OFF;
      end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Tick counter for one phase; done fires on the tick that completes the phase.
module tlc_phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  assign done = tick && (cnt == (limit - CNT_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || done) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tlc_phase_ctrl.sv
// Four-approach junction phase sequencer with demand-driven side phase, pedestrian walk and night flash.
module tlc_phase_ctrl
  import tlc_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned T_MAIN_GRN = 7,
  parameter int unsigned T_MT_GRN   = 5,
  parameter int unsigned T_SIDE_GRN = 3,
  parameter int unsigned T_PED_EXT  = 2,
  parameter int unsigned T_YEL      = 2,
  parameter int unsigned T_ALLRED   = 1,
  parameter int unsigned SIDE_SKIP  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       flash_en,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S,
  output logic       ped_walk,
  output logic [3:0] state_o
);

  localparam logic [CNT_W-1:0] LIM_MAIN   = CNT_W'(T_MAIN_GRN);
  localparam logic [CNT_W-1:0] LIM_MT     = CNT_W'(T_MT_GRN);
  localparam logic [CNT_W-1:0] LIM_SIDE   = CNT_W'(T_SIDE_GRN);
  localparam logic [CNT_W-1:0] LIM_PED    = CNT_W'(T_SIDE_GRN + T_PED_EXT);
  localparam logic [CNT_W-1:0] LIM_YEL    = CNT_W'(T_YEL);
  localparam logic [CNT_W-1:0] LIM_ALLRED = CNT_W'(T_ALLRED);
  localparam logic             SKIP_EN    = (SIDE_SKIP != 32'd0);

  state_t           state, state_nxt;
  logic             side_pend, side_pend_nxt;
  logic             ped_pend, ped_pend_nxt;
  logic             ped_srv, ped_srv_nxt;
  logic             blink, blink_nxt;
  logic [CNT_W-1:0] limit;
  logic             clr;
  logic             done;
  lights_t          lights_nxt;

  tlc_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .clr   (clr),
    .limit (limit),
    .done  (done)
  );

  // Next-state, demand latching and phase-length selection.
  always_comb begin
    state_nxt     = state;
    side_pend_nxt = side_pend | side_req;
    ped_pend_nxt  = ped_pend | ped_req;
    ped_srv_nxt   = ped_srv;
    blink_nxt     = blink;
    limit         = LIM_ALLRED;
    clr           = 1'b0;
    case (state)
      MAIN_GRN: begin
        limit = LIM_MAIN;
        if (done) state_nxt = M2_YEL;
      end
      M2_YEL: begin
        limit = LIM_YEL;
        if (done) state_nxt = MT_GRN;
      end
      MT_GRN: begin
        limit = LIM_MT;
        if (done) state_nxt = M1MT_YEL;
      end
      M1MT_YEL: begin
        limit = LIM_YEL;
        if (done) state_nxt = ALLRED1;
      end
      ALLRED1: begin
        limit = LIM_ALLRED;
        if (done) begin
          if (!SKIP_EN || side_pend || ped_pend) begin
            // A request arriving on this very edge re-arms its latch for the next cycle.
            state_nxt     = SIDE_GRN;
            ped_srv_nxt   = ped_pend;
            side_pend_nxt = side_req;
            ped_pend_nxt  = ped_req;
          end else begin
            state_nxt = MAIN_GRN;
          end
        end
      end
      SIDE_GRN: begin
        limit = ped_srv ? LIM_PED : LIM_SIDE;
        if (done) begin
          state_nxt   = SIDE_YEL;
          ped_srv_nxt = 1'b0;
        end
      end
      SIDE_YEL: begin
        limit = LIM_YEL;
        if (done) state_nxt = ALLRED2;
      end
      ALLRED2: begin
        limit = LIM_ALLRED;
        if (done) begin
          if (flash_en) begin
            state_nxt = FLASH;
            blink_nxt = 1'b1;
          end else begin
            state_nxt = MAIN_GRN;
          end
        end
      end
      FLASH: begin
        clr = 1'b1;
        if (tick) begin
          blink_nxt = ~blink;
          if (!flash_en) state_nxt = ALLRED2;
        end
      end
      default: begin
        clr       = 1'b1;
        state_nxt = ALLRED2;
      end
    endcase
  end

  assign lights_nxt = decode_lights(state_nxt, blink_nxt);

  // Outputs are registered from the next-state decode so they move on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ALLRED2;
      side_pend <= 1'b0;
      ped_pend  <= 1'b0;
      ped_srv   <= 1'b0;
      blink     <= 1'b1;
      light_M1  <= LT_RED;
      light_M2  <= LT_RED;
      light_MT  <= LT_RED;
      light_S   <= LT_RED;
      ped_walk  <= 1'b0;
      state_o   <= 4'(ALLRED2);
    end else begin
      state     <= state_nxt;
      side_pend <= side_pend_nxt;
      ped_pend  <= ped_pend_nxt;
      ped_srv   <= ped_srv_nxt;
      blink     <= blink_nxt;
      light_M1  <= lights_nxt.m1;
      light_M2  <= lights_nxt.m2;
      light_MT  <= lights_nxt.mt;
      light_S   <= lights_nxt.s;
      ped_walk  <= (state_nxt == SIDE_GRN) && ped_srv_nxt;
      state_o   <= 4'(state_nxt);
    end
  end

endmodule

// File: tb/tb_tlc_phase_ctrl.sv
// Directed bench for tlc_phase_ctrl with default parameters; one tick every 4 clocks.
module tb_tlc_phase_ctrl;
  import tlc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       flash_en = 1'b0;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] light_M1, light_M2, light_MT, light_S;
  logic       ped_walk;
  logic [3:0] state_o;

  int errors = 0;
  int checks = 0;

  tlc_phase_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .flash_en (flash_en),
    .side_req (side_req),
    .ped_req  (ped_req),
    .light_M1 (light_M1),
    .light_M2 (light_M2),
    .light_MT (light_MT),
    .light_S  (light_S),
    .ped_walk (ped_walk),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  // Expected lamps {M1,M2,MT,S} written out from the phase table.
  function automatic logic [11:0] exp_lights(state_t st, bit blink);
    case (st)
      MAIN_GRN: return {3'b001, 3'b001, 3'b100, 3'b100};
      M2_YEL:   return {3'b001, 3'b010, 3'b100, 3'b100};
      MT_GRN:   return {3'b001, 3'b100, 3'b001, 3'b100};
      M1MT_YEL: return {3'b010, 3'b100, 3'b010, 3'b100};
      SIDE_GRN: return {3'b100, 3'b100, 3'b100, 3'b001};
      SIDE_YEL: return {3'b100, 3'b100, 3'b100, 3'b010};
      FLASH:    return blink ? {3'b010, 3'b010, 3'b100, 3'b100} : 12'h000;
      default:  return {3'b100, 3'b100, 3'b100, 3'b100};
    endcase
  endfunction

  task automatic check(input string tag, input state_t st, input bit walk, input bit blink);
    logic [16:0] obs, exp;
    obs = {state_o, light_M1, light_M2, light_MT, light_S, ped_walk};
    exp = {4'(st), exp_lights(st, blink), walk};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
  endtask

  task automatic tick_once();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Checks the state holds for n ticks, issuing each tick after the check.
  task automatic dwell(input string tag, input state_t st, input int n, input bit walk);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s/%s#%0d", tag, st.name(), i), st, walk, 1'b1);
      tick_once();
    end
  endtask

  task automatic main_to_mt(input string tag);
    dwell(tag, MAIN_GRN, 7, 1'b0);
    dwell(tag, M2_YEL, 2, 1'b0);
  endtask

  task automatic mt_to_ar1(input string tag);
    dwell(tag, MT_GRN, 5, 1'b0);
    dwell(tag, M1MT_YEL, 2, 1'b0);
    dwell(tag, ALLRED1, 1, 1'b0);
  endtask

  task automatic side_to_main(input string tag, input int side_len, input bit walk);
    dwell(tag, SIDE_GRN, side_len, walk);
    dwell(tag, SIDE_YEL, 2, 1'b0);
    dwell(tag, ALLRED2, 1, 1'b0);
  endtask

  initial begin
    // Reset values
    #12;
    check("reset", ALLRED2, 1'b0, 1'b1);
    @(negedge clk) rst_n = 1'b1;

    // Full 23-tick cycle with side demand held
    side_req = 1'b1;
    dwell("A", ALLRED2, 1, 1'b0);
    main_to_mt("A");
    mt_to_ar1("A");
    side_to_main("A", 3, 1'b0);
    side_req = 1'b0;

    // Latch left set by the held request serves one more side phase
    main_to_mt("A2");
    mt_to_ar1("A2");
    side_to_main("A2", 3, 1'b0);

    // No demand: side phase skipped, 17-tick cycle
    main_to_mt("B");
    mt_to_ar1("B");

    // One-clock pedestrian pulse in MT_GRN extends side green with walk
    main_to_mt("C");
    ped_req = 1'b1;
    @(negedge clk) ped_req = 1'b0;
    mt_to_ar1("C");
    side_to_main("C", 5, 1'b1);
    main_to_mt("C2");
    mt_to_ar1("C2");

    // side_req coincident with the ALLRED1 -> SIDE_GRN edge is kept for next cycle
    main_to_mt("E");
    side_req = 1'b1;
    @(negedge clk) side_req = 1'b0;
    dwell("E", MT_GRN, 5, 1'b0);
    dwell("E", M1MT_YEL, 2, 1'b0);
    check("E/ar1", ALLRED1, 1'b0, 1'b1);
    @(negedge clk) begin tick = 1'b1; side_req = 1'b1; end
    @(negedge clk) begin tick = 1'b0; side_req = 1'b0; end
    @(negedge clk);
    @(negedge clk);
    checks++;
    assert (dut.side_pend === 1'b1) else begin
      errors++;
      $error("FAIL E/side_pend: observed %b expected 1", dut.side_pend);
    end
    side_to_main("E", 3, 1'b0);

    // Second side service, with flash requested mid MT_GRN
    main_to_mt("D");
    flash_en = 1'b1;
    mt_to_ar1("D");
    side_to_main("D", 3, 1'b0);
    check("D/flash0", FLASH, 1'b0, 1'b1);
    tick_once();
    check("D/flash1", FLASH, 1'b0, 1'b0);
    tick_once();
    check("D/flash2", FLASH, 1'b0, 1'b1);
    tick_once();
    check("D/flash3", FLASH, 1'b0, 1'b0);
    flash_en = 1'b0;
    tick_once();
    dwell("D", ALLRED2, 1, 1'b0);

    // Asynchronous reset in the middle of a pedestrian side phase
    ped_req = 1'b1;
    @(negedge clk) ped_req = 1'b0;
    main_to_mt("F");
    mt_to_ar1("F");
    check("F/side", SIDE_GRN, 1'b1, 1'b1);
    tick_once();
    check("F/side1", SIDE_GRN, 1'b1, 1'b1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("F/async_rst", ALLRED2, 1'b0, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    dwell("F", ALLRED2, 1, 1'b0);
    check("F/idle0", MAIN_GRN, 1'b0, 1'b1);
    repeat (100) @(negedge clk);
    check("F/idle100", MAIN_GRN, 1'b0, 1'b1);
    dwell("F2", MAIN_GRN, 7, 1'b0);
    check("F/m2y", M2_YEL, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
